// File: rtl/audio_pkg.sv
// Shared constants for the audio output path: slot geometry and LRCK encoding.
package audio_pkg;

  // Width of one PCM sample and of one I2S slot, in bits.
  localparam int SAMPLE_W = 16;

  // One stereo I2S frame is a left slot followed by a right slot.
  localparam int FRAME_BITS = 2 * SAMPLE_W;

  // Word-select encoding seen by the codec.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding PCM samples.
// A write while full is accepted only if a read frees a slot in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Sample storage; contents are only observed while level is non-zero.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_wr && !do_rd) begin
        level <= level + 1'b1;
      end else if (do_rd && !do_wr) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: buffers mono samples and sends each one on both
// the left and right slot of a frame, generating BCLK and LRCK itself.
//
// Write interface: wr is a one-cycle strobe with no back-pressure. A strobe
// is always consumed on the cycle it is high; if the FIFO is full and no
// frame load frees a slot that cycle, the sample is dropped and overflow
// latches until reset. full/level are advisory for the producer.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int DEPTH    = 8,
  parameter int BCLK_DIV = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [SAMPLE_W-1:0]    sample,
  input  logic                   wr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underrun,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BC_W    = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0]  BC_HALF  = BC_W'(SAMPLE_W);

  logic [DIV_W-1:0]    div_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic [BC_W-1:0]     bit_cnt_nxt;
  logic [FRAME_W-1:0]  frame_word;
  logic [FRAME_W-1:0]  load_word;
  logic [SAMPLE_W-1:0] last_sample;
  logic [SAMPLE_W-1:0] head;
  logic [SAMPLE_W-1:0] load_sample;
  logic                fall_evt;
  logic                load_evt;
  logic                pop;

  // Serial state only moves on the BCLK falling event so the codec sees
  // stable LRCK/SDATA at every rising edge.
  assign fall_evt    = (div_cnt == DIV_LAST) && i2s_bclk;
  assign bit_cnt_nxt = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
  assign load_evt    = fall_evt && (bit_cnt == '0);
  assign pop         = load_evt && !empty;
  assign load_sample = pop ? head : last_sample;
  assign load_word   = {load_sample, load_sample};

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr),
    .wr_data (sample),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // BCLK divider: toggle the bit clock each time div_cnt wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame sequencer: bit counter, LRCK, frame load and one-bit-delayed SDATA.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      frame_word  <= '0;
      last_sample <= '0;
      i2s_lrck    <= LRCK_LEFT;
      i2s_sdata   <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt  <= bit_cnt_nxt;
      i2s_lrck <= (bit_cnt_nxt >= BC_HALF) ? LRCK_RIGHT : LRCK_LEFT;
      if (load_evt) begin
        // New frame: the left-slot MSB goes out immediately after the load.
        frame_word  <= load_word;
        last_sample <= load_sample;
        i2s_sdata   <= load_word[FRAME_W-1];
      end else begin
        // Bit for the new count is frame_word[top - (new-1)] = [top - old].
        i2s_sdata <= frame_word[BC_LAST - bit_cnt];
      end
    end
  end

  // Status flags: underrun pulses on a load that found the FIFO empty;
  // overflow latches on a dropped write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load_evt && empty;
      if (wr && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a cycle-counting reference queue predicts which
// sample each frame carries; a monitor deserialises the I2S stream and
// compares every completed frame against the expected queue.
module tb_audio_i2s_tx;

  localparam int SAMPLE_W   = 16;
  localparam int DEPTH      = 8;
  localparam int LVL_W      = $clog2(DEPTH) + 1;
  localparam int FRAME_CYC  = 1024;
  localparam int FIRST_LOAD = 32;

  typedef struct {
    logic [SAMPLE_W-1:0] smp;
    logic [LVL_W-1:0]    lvl;
    logic                full;
    logic                empty;
    logic                ovf;
  } vec_t;

  logic                clock;
  logic                reset_n;
  logic [SAMPLE_W-1:0] sample;
  logic                wr;
  logic                full;
  logic                empty;
  logic [LVL_W-1:0]    level;
  logic                overflow;
  logic                underrun;
  logic                i2s_bclk;
  logic                i2s_lrck;
  logic                i2s_sdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [SAMPLE_W-1:0] exp_q[$];
  logic [SAMPLE_W-1:0] ref_q[$];
  logic [SAMPLE_W-1:0] ref_last = '0;
  logic                m_ovf    = 1'b0;
  logic                m_rst    = 1'b1;
  int                  m_cyc    = 0;
  int                  m_under_cnt = 0;

  // Monitor state
  int                  mon_k   = 0;
  int                  mon_idx = 0;
  logic                mon_prev = 1'b0;
  logic                mon_lr_bad = 1'b0;
  logic [SAMPLE_W-1:0] mon_left  = '0;
  logic [SAMPLE_W-1:0] mon_right = '0;
  logic [SAMPLE_W-1:0] mon_exp;
  int                  dut_under_cnt = 0;

  vec_t tab [9];

  audio_i2s_tx #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .BCLK_DIV (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sample    (sample),
    .wr        (wr),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .underrun  (underrun),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts cycles since reset release, pops at each frame load
  // (before accepting a same-cycle write), and queues the sample each frame carries.
  initial begin
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        m_rst    = 1'b1;
        m_cyc    = 0;
        ref_last = '0;
        m_ovf    = 1'b0;
        ref_q.delete();
        exp_q.delete();
      end else begin
        m_rst = 1'b0;
        m_cyc++;
        if (m_cyc >= FIRST_LOAD && ((m_cyc - FIRST_LOAD) % FRAME_CYC) == 0) begin
          if (ref_q.size() != 0) ref_last = ref_q.pop_front();
          else m_under_cnt++;
          exp_q.push_back(ref_last);
        end
        if (wr) begin
          if (ref_q.size() < DEPTH) ref_q.push_back(sample);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: sample LRCK/SDATA at each BCLK rise, rebuild both slots, compare.
  initial begin
    forever begin
      @(negedge clock);
      if (m_rst) begin
        mon_k      = 0;
        mon_prev   = 1'b0;
        mon_lr_bad = 1'b0;
        mon_left   = '0;
        mon_right  = '0;
      end else begin
        if (underrun === 1'b1) dut_under_cnt++;
        if (i2s_bclk === 1'b1 && !mon_prev) begin
          mon_idx = mon_k % 32;
          if (i2s_lrck !== (mon_idx >= 16)) mon_lr_bad = 1'b1;
          if (mon_idx >= 1 && mon_idx <= 16) mon_left = {mon_left[SAMPLE_W-2:0], i2s_sdata};
          else if (mon_k > 0) mon_right = {mon_right[SAMPLE_W-2:0], i2s_sdata};
          if (mon_idx == 0 && mon_k > 0) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_queued: frame completed but no expected sample queued");
            end else begin
              mon_exp = exp_q.pop_front();
              check("frame_left", 32'(mon_left), 32'(mon_exp));
              check("frame_right", 32'(mon_right), 32'(mon_exp));
              check("frame_lrck_bad", 32'(mon_lr_bad), 32'd0);
            end
            mon_lr_bad = 1'b0;
          end
          mon_k++;
        end
        mon_prev = i2s_bclk;
      end
    end
  end

  // Driver tasks
  task automatic goto(input int target);
    int guard = 0;
    while (m_cyc != target && guard < 20000) begin
      @(negedge clock);
      guard++;
    end
    if (m_cyc != target) check("goto_timeout", 32'(m_cyc), 32'(target));
  endtask

  task automatic do_wr(input logic [SAMPLE_W-1:0] s);
    wr     = 1'b1;
    sample = s;
    @(negedge clock);
    wr     = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_values();
    check("rst_bclk", 32'(i2s_bclk), 32'd0);
    check("rst_lrck", 32'(i2s_lrck), 32'd0);
    check("rst_sdata", 32'(i2s_sdata), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
  endtask

  task automatic check_timing();
    goto(15);
    check("bclk_before_rise", 32'(i2s_bclk), 32'd0);
    goto(16);
    check("bclk_rise_16", 32'(i2s_bclk), 32'd1);
    check("lrck_first_rise", 32'(i2s_lrck), 32'd0);
    goto(31);
    check("bclk_before_fall", 32'(i2s_bclk), 32'd1);
    goto(32);
    check("bclk_fall_32", 32'(i2s_bclk), 32'd0);
    check("underrun_first_load", 32'(underrun), 32'd1);
    goto(33);
    check("underrun_one_cycle", 32'(underrun), 32'd0);
  endtask

  initial begin
    tab[0] = '{16'h0001, 4'd1, 1'b0, 1'b0, 1'b0};
    tab[1] = '{16'h7FFF, 4'd2, 1'b0, 1'b0, 1'b0};
    tab[2] = '{16'h8000, 4'd3, 1'b0, 1'b0, 1'b0};
    tab[3] = '{16'hFFFF, 4'd4, 1'b0, 1'b0, 1'b0};
    tab[4] = '{16'h1234, 4'd5, 1'b0, 1'b0, 1'b0};
    tab[5] = '{16'hCAFE, 4'd6, 1'b0, 1'b0, 1'b0};
    tab[6] = '{16'h5A5A, 4'd7, 1'b0, 1'b0, 1'b0};
    tab[7] = '{16'h0F0F, 4'd8, 1'b1, 1'b0, 1'b0};
    tab[8] = '{16'hDEAD, 4'd8, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0;
    wr      = 1'b0;
    sample  = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Reset release with no writes: reset values, BCLK timing, silent frames.
    check_reset_values();
    check_timing();
    goto(FIRST_LOAD + 2 * FRAME_CYC + 1);
    check("underrun_count_idle", 32'(dut_under_cnt), 32'(m_under_cnt));

    // Single sample A5C3: level 1 until the load event pops it.
    goto(2100);
    do_wr(16'hA5C3);
    check("a5c3_level_after_wr", 32'(level), 32'd1);
    check("a5c3_not_empty", 32'(empty), 32'd0);
    goto(FIRST_LOAD + 3 * FRAME_CYC - 1);
    check("a5c3_level_before_load", 32'(level), 32'd1);
    goto(FIRST_LOAD + 3 * FRAME_CYC);
    check("a5c3_level_after_load", 32'(level), 32'd0);

    // Nine back-to-back writes into a depth-8 FIFO.
    goto(3200);
    for (int i = 0; i < 9; i++) begin
      wr     = 1'b1;
      sample = tab[i].smp;
      @(negedge clock);
      check($sformatf("tab_level_%0d", i), 32'(level), 32'(tab[i].lvl));
      check($sformatf("tab_full_%0d", i), 32'(full), 32'(tab[i].full));
      check($sformatf("tab_empty_%0d", i), 32'(empty), 32'(tab[i].empty));
      check($sformatf("tab_overflow_%0d", i), 32'(overflow), 32'(tab[i].ovf));
    end
    wr = 1'b0;

    // Drain all eight; overflow must stay latched.
    goto(FIRST_LOAD + 11 * FRAME_CYC + 1);
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_level", 32'(level), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Starve after 8001: replayed on later frames, one underrun per frame.
    goto(11400);
    do_wr(16'h8001);
    goto(FIRST_LOAD + 14 * FRAME_CYC + 1);
    check("underrun_count_starve", 32'(dut_under_cnt), 32'(m_under_cnt));

    // Write on the exact load cycle with the FIFO empty.
    goto(FIRST_LOAD + 15 * FRAME_CYC - 1);
    do_wr(16'h3C3C);
    check("empty_load_underrun", 32'(underrun), 32'd1);
    check("empty_load_level", 32'(level), 32'd1);

    // Mid-frame reset at bit_cnt 20 with three samples buffered.
    goto(FIRST_LOAD + 16 * FRAME_CYC + 100);
    for (int i = 0; i < 3; i++) do_wr(16'(($urandom_range(0, 65535))));
    goto(FIRST_LOAD + 16 * FRAME_CYC + 19 * 32 + 6);
    check("midframe_level", 32'(level), 32'd3);
    check("midframe_lrck", 32'(i2s_lrck), 32'd1);
    pulse_reset();
    check_reset_values();
    check_timing();

    // Write on the exact load cycle with the FIFO full.
    goto(100);
    for (int i = 0; i < DEPTH; i++) do_wr(16'(($urandom_range(0, 65535))));
    check("refill_full", 32'(full), 32'd1);
    goto(FIRST_LOAD + FRAME_CYC - 1);
    do_wr(16'(($urandom_range(0, 65535))));
    check("full_load_level", 32'(level), 32'd8);
    check("full_load_overflow", 32'(overflow), 32'(m_ovf));
    check("full_load_no_overflow", 32'(overflow), 32'd0);
    check("full_load_underrun", 32'(underrun), 32'd0);

    goto(FIRST_LOAD + 3 * FRAME_CYC + 100);
    check("level_model_final", 32'(level), 32'(ref_q.size()));
    check("underrun_count_final", 32'(dut_under_cnt), 32'(m_under_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
